// File: rtl/demux1t2_5_buf.sv
// 1-to-2 demultiplexer: each input word is steered by in_sel into one of two
// small output FIFOs with valid/ready handshakes and per-channel pop counters.
module demux1t2_5_buf #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             o0_valid,
   input  logic             o0_ready,
   output logic [WIDTH-1:0] o0_data,
   output logic             o1_valid,
   input  logic             o1_ready,
   output logic [WIDTH-1:0] o1_data,
   output logic [CNT_W-1:0] o0_cnt,
   output logic [CNT_W-1:0] o1_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [1:0]            full;
   logic [1:0]            empty;
   logic [1:0]            push;
   logic [1:0]            pop;
   logic [1:0]            rdy;
   logic [1:0][WIDTH-1:0] head;
   logic [1:0][CNT_W-1:0] cnt;

   assign rdy = {o1_ready, o0_ready};

   // No bypass when full: a same-cycle pop never frees a slot for the push.
   assign in_ready = !full[in_sel];

   for (genvar k = 0; k < 2; k++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wptr;
      logic [AW-1:0]    rptr;
      logic [AW:0]      occ;
      logic [CNT_W-1:0] pop_cnt;

      assign full[k]  = (occ == (AW+1)'(DEPTH));
      assign empty[k] = (occ == '0);
      assign push[k]  = in_valid && in_ready && (in_sel == 1'(k));
      assign pop[k]   = !empty[k] && rdy[k];
      assign head[k]  = empty[k] ? '0 : mem[rptr];
      assign cnt[k]   = pop_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            // NOTE: storage is cleared on reset too, so no word written before a
            // mid-operation reset can ever reappear at a head afterwards.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            pop_cnt <= '0;
         end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, whatever order these statements appear in.
            if (push[k]) begin
               mem[wptr] <= in_data;
               wptr      <= wptr + AW'(1);
            end
            if (pop[k]) begin
               rptr    <= rptr + AW'(1);
               pop_cnt <= pop_cnt + CNT_W'(1);
            end
            case ({push[k], pop[k]})
               2'b10:   occ <= occ + (AW+1)'(1);
               2'b01:   occ <= occ - (AW+1)'(1);
               default: occ <= occ;
            endcase
         end
      end
   end

   assign o0_valid = !empty[0];
   assign o1_valid = !empty[1];
   assign o0_data  = head[0];
   assign o1_data  = head[1];
   assign o0_cnt   = cnt[0];
   assign o1_cnt   = cnt[1];

endmodule

// File: tb/tb_demux1t2_5_buf.sv
// Directed bench for demux1t2_5_buf: per-channel scoreboard queues filled on
// accepted pushes and drained on handshaken pops.
module tb_demux1t2_5_buf;

   localparam int WIDTH = 5;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             o0_valid, o1_valid;
   logic             o0_ready, o1_ready;
   logic [WIDTH-1:0] o0_data, o1_data;
   logic [CNT_W-1:0] o0_cnt, o1_cnt;

   demux1t2_5_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_data(o0_data),
      .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_data(o1_data),
      .o0_cnt(o0_cnt), .o1_cnt(o1_cnt)
   );

   always #5 clk = ~clk;

   int               n_cmp = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   logic [CNT_W-1:0] m_cnt0 = '0;
   logic [CNT_W-1:0] m_cnt1 = '0;
   logic [CNT_W-1:0] saved_cnt0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      o0_ready = r0;
      o1_ready = r1;
      #1;
   endtask

   // Compare DUT against the model, then advance the model by this cycle's handshakes.
   task automatic eval(input string tag);
      logic exp_rdy;
      exp_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      check({tag, ".o0_valid"}, 32'(o0_valid), 32'(q0.size() != 0));
      check({tag, ".o1_valid"}, 32'(o1_valid), 32'(q1.size() != 0));
      check({tag, ".o0_data"}, 32'(o0_data), (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
      check({tag, ".o1_data"}, 32'(o1_data), (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
      check({tag, ".o0_cnt"}, 32'(o0_cnt), 32'(m_cnt0));
      check({tag, ".o1_cnt"}, 32'(o1_cnt), 32'(m_cnt1));
      if (q0.size() != 0 && o0_ready) begin
         void'(q0.pop_front());
         m_cnt0++;
      end
      if (q1.size() != 0 && o1_ready) begin
         void'(q1.pop_front());
         m_cnt1++;
      end
      if (in_valid && exp_rdy) begin
         if (in_sel) q1.push_back(in_data);
         else        q0.push_back(in_data);
      end
   endtask

   task automatic step(input string tag, input logic v, input logic s,
                       input logic [WIDTH-1:0] d, input logic r0, input logic r1);
      @(negedge clk);
      set_in(v, s, d, r0, r1);
      eval(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
      #100;
      check("rst.in_ready", 32'(in_ready), 32'h1);
      check("rst.o0_valid", 32'(o0_valid), 32'h0);
      check("rst.o1_valid", 32'(o1_valid), 32'h0);
      check("rst.o0_data", 32'(o0_data), 32'h0);
      check("rst.o1_data", 32'(o1_data), 32'h0);
      check("rst.o0_cnt", 32'(o0_cnt), 32'h0);
      check("rst.o1_cnt", 32'(o1_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Steering to each channel.
      step("steer0", 1'b1, 1'b0, 5'h01, 1'b1, 1'b1);
      step("steer1", 1'b1, 1'b1, 5'h1F, 1'b1, 1'b1);
      step("steer2", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      step("steer3", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      check("steer.o0_cnt", 32'(o0_cnt), 32'h1);
      check("steer.o1_cnt", 32'(o1_cnt), 32'h1);

      // Backpressure on channel 0; channel 1 stays usable in the blocked cycle.
      step("bp0", 1'b1, 1'b0, 5'h03, 1'b0, 1'b1);
      step("bp1", 1'b1, 1'b0, 5'h05, 1'b0, 1'b1);
      @(negedge clk);
      set_in(1'b1, 1'b0, 5'h07, 1'b0, 1'b1);
      check("bp.full_rdy", 32'(in_ready), 32'h0);
      set_in(1'b1, 1'b1, 5'h09, 1'b0, 1'b1);
      eval("bp.other_ch");

      // Full with same-cycle pop: no push, then push lands, then full again.
      step("fp.pop_no_push", 1'b1, 1'b0, 5'h07, 1'b1, 1'b1);
      step("fp.push", 1'b1, 1'b0, 5'h07, 1'b0, 1'b1);
      step("fp.full_again", 1'b1, 1'b0, 5'h0B, 1'b0, 1'b1);
      step("fp.drain0", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      step("fp.drain1", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      step("fp.drain2", 1'b0, 1'b0, '0, 1'b1, 1'b1);

      // Counter wrap on channel 1 while channel 0 stays idle.
      saved_cnt0 = m_cnt0;
      for (int i = 0; i < 300; i++) begin
         step("wrap", 1'b1, 1'b1, 5'(i), 1'b0, 1'b1);
         if (m_cnt1 == '0) break;
      end
      @(negedge clk);
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("wrap.o1_cnt", 32'(o1_cnt), 32'h0);
      check("wrap.o0_cnt", 32'(o0_cnt), 32'(saved_cnt0));
      eval("wrap.after");
      step("wrap.drain0", 1'b0, 1'b0, '0, 1'b0, 1'b1);
      step("wrap.drain1", 1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Fill both FIFOs, then reset asynchronously between edges.
      step("fill0", 1'b1, 1'b0, 5'h11, 1'b0, 1'b0);
      step("fill1", 1'b1, 1'b0, 5'h12, 1'b0, 1'b0);
      step("fill2", 1'b1, 1'b1, 5'h13, 1'b0, 1'b0);
      step("fill3", 1'b1, 1'b1, 5'h14, 1'b0, 1'b0);
      step("fill.full", 1'b1, 1'b1, 5'h15, 1'b0, 1'b0);
      @(negedge clk);
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("mrst.o0_valid", 32'(o0_valid), 32'h0);
      check("mrst.o1_valid", 32'(o1_valid), 32'h0);
      check("mrst.o0_data", 32'(o0_data), 32'h0);
      check("mrst.o1_data", 32'(o1_data), 32'h0);
      check("mrst.o0_cnt", 32'(o0_cnt), 32'h0);
      check("mrst.o1_cnt", 32'(o1_cnt), 32'h0);
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post0", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      step("post1", 1'b1, 1'b1, 5'h0A, 1'b1, 1'b1);
      step("post2", 1'b1, 1'b0, 5'h15, 1'b1, 1'b1);
      step("post3", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      step("post4", 1'b0, 1'b0, '0, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/demux1t2_5_buf.md
Name: demux1t2_5_buf

Overview:
- Inverse of the 5-bit 2:1 select path: one input stream is steered to one of two output channels by a per-word select bit.
- Each output channel has its own small FIFO and a valid/ready handshake, so a stalled consumer on one side does not lose data.
- It sits between a single producer and two independent consumers in the datapath test harness.
- It also counts the words delivered on each channel.

Parameters:
- WIDTH, 5: data width of the input and both outputs.
- DEPTH, 2: entries per output FIFO; a power of two, at least 2.
- CNT_W, 8: width of each delivered-word counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word will be accepted this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  1  destination: 0 -> channel 0, 1 -> channel 1.
- o0_valid  out  1  channel 0 head valid.
- o0_ready  in  1  channel 0 consumer accepts the head.
- o0_data  out  WIDTH  channel 0 head word.
- o1_valid  out  1  channel 1 head valid.
- o1_ready  in  1  channel 1 consumer accepts the head.
- o1_data  out  WIDTH  channel 1 head word.
- o0_cnt  out  CNT_W  words popped from channel 0.
- o1_cnt  out  CNT_W  words popped from channel 1.

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately clears both FIFOs (pointers and occupancy) and all storage.
  - o0_valid=o1_valid=0, o0_data=o1_data=0, o0_cnt=o1_cnt=0.
  - Reset mid-operation discards all buffered words; no partial state survives.
- Push:
  - in_ready = !full[in_sel], a combinational function of in_sel and FIFO state only; it does not depend on in_valid.
  - A push occurs when in_valid && in_ready; in_data is written to the tail of FIFO[in_sel] on that rising edge.
  - The non-selected FIFO is never written.
- Pop:
  - ok_valid = !empty[k]; ok_data = head entry of FIFO k.
  - ok_data is 0 whenever FIFO k is empty.
  - A pop occurs when ok_valid && ok_ready. The head advances on that edge and ok_cnt increments by 1, wrapping modulo 2^CNT_W.
- Latency: a word accepted at edge N is visible on ok_valid/ok_data after edge N. No combinational input-to-output pass-through.
- Ordering: strict FIFO order within a channel. No ordering relation between channels.
- Full FIFO:
  - in_ready=0 for that select, even if a pop on that channel occurs in the same cycle. No bypass on full.
  - The other channel remains independently usable.
- Empty FIFO: ok_ready is ignored and the counter does not change.
- Simultaneous push and pop on the same non-full, non-empty channel: occupancy unchanged, both pointers advance.
- Simultaneous push and pop on the same empty channel: the push lands; the pop is not taken because valid=0. Occupancy becomes 1.
- Pop on one channel with a push to the other in the same cycle: both occur.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. Occupancy is held in a separate counter of log2(DEPTH)+1 bits.
- in_sel and in_data are only sampled when a push occurs. Changing in_sel while in_valid=1 and in_ready=0 is legal, and in_ready re-evaluates in the same cycle.

Test Plan:
- Reset then idle: hold rst_n=0 for 100 ns with inputs 0, then release -> in_ready=1, o0_valid=o1_valid=0, both data=0, both cnt=0.
- Steering: push 5'h01 sel=0 then 5'h1F sel=1, both ready=1 -> o0_data=01 one cycle after the first push, o1_data=1F one cycle after the second; o0_cnt=1, o1_cnt=1.
- Backpressure/full: o0_ready=0, push 03, 05, 07 with sel=0 -> first two accepted, in_ready=0 on the third. Push 09 with sel=1 in that cycle -> accepted. Raise o0_ready -> 03 then 05 pop in order; 07 is accepted once space frees.
- Full with same-cycle pop: channel 0 full, o0_ready=1, in_valid=1 sel=0 -> no push that cycle; push is accepted the next cycle; occupancy 2 -> 1 -> 2 pattern verified.
- Counter wrap: pop 256 words on channel 1 with CNT_W=8 -> o1_cnt returns to 0; o0_cnt unchanged.
- Reset mid-operation: both FIFOs holding 2 words, pulse rst_n low asynchronously between edges -> valids drop immediately; after release, cnt=0 and no stale word appears.
